// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between NREQ requesters, one op in flight.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr pointer).
module addsub_arbiter #(
    parameter int WIDTH     = 16,
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int ADDER_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_as,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_as,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic                    busy
);

    localparam int CNTW = (ADDER_LAT > 0) ? $clog2(ADDER_LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [IDW-1:0]  start;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;
    logic            found;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IDW-1:0] rr_ptr;
    assign start = rr_ptr;
`endif

    // Search starts at the priority pointer and wraps; reset forces the grant low.
    always_comb begin
        req_ready = '0;
        win       = '0;
        idx       = '0;
        found     = 1'b0;
        if (state == IDLE && !reset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(start) + k) % NREQ);
                if (!found && req_valid[idx]) begin
                    found          = 1'b1;
                    req_ready[idx] = 1'b1;
                    win            = idx;
                end
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_as    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        add_a  <= req_a[win*WIDTH +: WIDTH];
                        add_b  <= req_b[win*WIDTH +: WIDTH];
                        add_as <= req_as[win];
                        rsp_id <= win;
                        cnt    <= CNTW'(ADDER_LAT);
                        state  <= WAIT;
                    end
                end
                // cnt reaches zero exactly when the adder output reflects the latched operands
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_sum   <= add_sum;
                        rsp_cout  <= add_cout;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
                        rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
